// File: rtl/m_mem_arbiter.sv
// m_mem_arbiter: two-port arbiter in front of a single-port synchronous-write /
// combinational-read memory. Port 0 is instruction fetch and port 1 is data.
// Port 1 has fixed priority. Reads return one cycle after the grant on the
// shared r_rdata bus, qualified by the per-port r_rvalid.
//
// Optional feature: define ARB_STARVE_GUARD_EN to add a starvation counter.
// After port 0 has been denied STARVE_MAX consecutive times, it wins over port 1.
//
// Ports:
//   w_clk, w_rst_n             clock, synchronous active-low reset
//   w_req*/w_we*/w_addr*/w_wdata*  per-port request, held until granted
//   w_gnt0/w_gnt1              combinational grant for the current cycle
//   r_rvalid0/r_rvalid1        registered read-data valid, one cycle after grant
//   r_rdata                    registered read data, shared by both ports
//   w_mem_addr/we/din          memory drive (muxed from the granted port)
//   w_mem_dout                 combinational memory read data
module m_mem_arbiter #(
    parameter int unsigned ADDR_W     = 11,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              w_clk,
    input  logic              w_rst_n,
    input  logic              w_req0,
    input  logic              w_req1,
    input  logic              w_we0,
    input  logic              w_we1,
    input  logic [ADDR_W-1:0] w_addr0,
    input  logic [ADDR_W-1:0] w_addr1,
    input  logic [DATA_W-1:0] w_wdata0,
    input  logic [DATA_W-1:0] w_wdata1,
    output logic              w_gnt0,
    output logic              w_gnt1,
    output logic              r_rvalid0,
    output logic              r_rvalid1,
    output logic [DATA_W-1:0] r_rdata,
    output logic [ADDR_W-1:0] w_mem_addr,
    output logic              w_mem_we,
    output logic [DATA_W-1:0] w_mem_din,
    input  logic [DATA_W-1:0] w_mem_dout
);

    localparam int unsigned STARVE_W = $clog2(STARVE_MAX) + 1;

    // A zero threshold would make the guard meaningless.
    if (STARVE_MAX < 1) begin : g_bad_starve_max
        $error("STARVE_MAX must be at least 1");
    end

    logic force0_c;

`ifdef ARB_STARVE_GUARD_EN
    logic [STARVE_W-1:0] r_starve;

    // Count consecutive denied cycles for port 0, saturating at the threshold.
    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            r_starve <= '0;
        end else if (w_req0 && !w_gnt0) begin
            if (r_starve != STARVE_W'(STARVE_MAX))
                r_starve <= r_starve + STARVE_W'(1);
        end else begin
            r_starve <= '0;
        end
    end

    assign force0_c = w_req0 && (r_starve == STARVE_W'(STARVE_MAX));
`else
    assign force0_c = 1'b0;
`endif

    // Grant selection. Reset suppresses all grants, so no write can occur in reset.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (w_rst_n) begin
            if (w_req1 && !force0_c)
                w_gnt1 = 1'b1;
            else if (w_req0)
                w_gnt0 = 1'b1;
        end
    end

    // Memory drive follows the granted port. With no grant, it is idle and zero.
    always_comb begin
        w_mem_addr = '0;
        w_mem_we   = 1'b0;
        w_mem_din  = '0;
        if (w_gnt1) begin
            w_mem_addr = w_addr1;
            w_mem_we   = w_we1;
            w_mem_din  = w_wdata1;
        end else if (w_gnt0) begin
            w_mem_addr = w_addr0;
            w_mem_we   = w_we0;
            w_mem_din  = w_wdata0;
        end
    end

    // Read return path. r_rdata only moves on a granted read.
    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_rvalid0 <= w_gnt0 && !w_we0;
            r_rvalid1 <= w_gnt1 && !w_we1;
            if ((w_gnt0 && !w_we0) || (w_gnt1 && !w_we1))
                r_rdata <= w_mem_dout;
        end
    end

endmodule

// File: tb/tb_m_mem_arbiter.sv
// tb_m_mem_arbiter: table-driven bench with a read-return scoreboard for m_mem_arbiter.
module tb_m_mem_arbiter;

    localparam int unsigned AW = 11;
    localparam int unsigned DW = 32;

    logic          w_clk, w_rst_n;
    logic          w_req0, w_req1, w_we0, w_we1;
    logic [AW-1:0] w_addr0, w_addr1;
    logic [DW-1:0] w_wdata0, w_wdata1;
    logic          w_gnt0, w_gnt1, r_rvalid0, r_rvalid1;
    logic [DW-1:0] r_rdata;
    logic [AW-1:0] w_mem_addr;
    logic          w_mem_we;
    logic [DW-1:0] w_mem_din, w_mem_dout;

    m_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
        .w_clk(w_clk), .w_rst_n(w_rst_n),
        .w_req0(w_req0), .w_req1(w_req1), .w_we0(w_we0), .w_we1(w_we1),
        .w_addr0(w_addr0), .w_addr1(w_addr1),
        .w_wdata0(w_wdata0), .w_wdata1(w_wdata1),
        .w_gnt0(w_gnt0), .w_gnt1(w_gnt1),
        .r_rvalid0(r_rvalid0), .r_rvalid1(r_rvalid1), .r_rdata(r_rdata),
        .w_mem_addr(w_mem_addr), .w_mem_we(w_mem_we), .w_mem_din(w_mem_din),
        .w_mem_dout(w_mem_dout)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    // Memory device seen by the DUT.
    logic [DW-1:0] mem     [0:2047];
    // Reference contents, updated only from the bench's expected grants.
    logic [DW-1:0] ref_mem [0:2047];

    assign w_mem_dout = mem[w_mem_addr];
    always @(posedge w_clk) if (w_mem_we) mem[w_mem_addr] <= w_mem_din;

    typedef struct packed {
        logic          req0;
        logic          we0;
        logic [AW-1:0] addr0;
        logic [DW-1:0] wdata0;
        logic          req1;
        logic          we1;
        logic [AW-1:0] addr1;
        logic [DW-1:0] wdata1;
        logic          g0;
        logic          g1;
    } vec_t;

    typedef struct {
        int            port;
        logic [DW-1:0] data;
    } sb_t;

    sb_t           sb[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] exp_rdata;
    vec_t          vecs[15];
    vec_t          idle;

    function automatic vec_t mk(input logic r0, input logic we0, input logic [AW-1:0] a0,
                                input logic [DW-1:0] d0, input logic r1, input logic we1,
                                input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                                input logic g0, input logic g1);
        vec_t v;
        v.req0 = r0; v.we0 = we0; v.addr0 = a0; v.wdata0 = d0;
        v.req1 = r1; v.we1 = we1; v.addr1 = a1; v.wdata1 = d1;
        v.g0 = g0; v.g1 = g1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, sample 2 units later, before the next posedge.
    task automatic step(input vec_t v, input logic rst);
        sb_t           e;
        logic          ewe;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        w_rst_n  = rst;
        w_req0   = v.req0;  w_we0 = v.we0;  w_addr0 = v.addr0; w_wdata0 = v.wdata0;
        w_req1   = v.req1;  w_we1 = v.we1;  w_addr1 = v.addr1; w_wdata1 = v.wdata1;
        #2;
        // Registered outputs from the previous edge.
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rvalid0", 32'(r_rvalid0), 32'(e.port == 0));
            chk("rvalid1", 32'(r_rvalid1), 32'(e.port == 1));
            chk("rdata", r_rdata, e.data);
            exp_rdata = e.data;
        end else begin
            chk("rvalid0_idle", 32'(r_rvalid0), 32'd0);
            chk("rvalid1_idle", 32'(r_rvalid1), 32'd0);
            chk("rdata_hold", r_rdata, exp_rdata);
        end
        // Combinational grant and memory drive.
        ewe = 1'b0; ea = '0; ed = '0;
        if (v.g1) begin ewe = v.we1; ea = v.addr1; ed = v.wdata1; end
        else if (v.g0) begin ewe = v.we0; ea = v.addr0; ed = v.wdata0; end
        chk("gnt0", 32'(w_gnt0), 32'(v.g0));
        chk("gnt1", 32'(w_gnt1), 32'(v.g1));
        chk("mem_we", 32'(w_mem_we), 32'(ewe));
        chk("mem_addr", 32'(w_mem_addr), 32'(ea));
        chk("mem_din", w_mem_din, ed);
        if (v.g0 || v.g1) begin
            if (ewe) begin
                ref_mem[ea] = ed;
            end else begin
                e.port = v.g1 ? 1 : 0;
                e.data = ref_mem[ea];
                sb.push_back(e);
            end
        end
        if (!rst) begin
            sb.delete();
            exp_rdata = '0;
        end
        @(negedge w_clk);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin
            mem[i]     = 32'hC0DE_0000 | 32'(i);
            ref_mem[i] = 32'hC0DE_0000 | 32'(i);
        end
        mem[16]     = 32'h1234_5678;
        ref_mem[16] = 32'h1234_5678;
        exp_rdata = '0;

        idle = mk(0, 0, 11'h000, 32'h0, 0, 0, 11'h000, 32'h0, 0, 0);
        vecs[0]  = idle;
        vecs[1]  = mk(1, 0, 11'h010, 32'h0,        0, 0, 11'h000, 32'h0,        1, 0);
        vecs[2]  = idle;
        vecs[3]  = mk(0, 0, 11'h000, 32'h0,        1, 1, 11'h7FF, 32'hDEADBEEF, 0, 1);
        vecs[4]  = mk(1, 0, 11'h7FF, 32'h0,        0, 0, 11'h000, 32'h0,        1, 0);
        vecs[5]  = mk(1, 0, 11'h001, 32'h0,        1, 0, 11'h002, 32'h0,        0, 1);
        vecs[6]  = mk(1, 0, 11'h001, 32'h0,        0, 0, 11'h000, 32'h0,        1, 0);
        vecs[7]  = mk(0, 0, 11'h000, 32'h0,        1, 0, 11'h002, 32'h0,        0, 1);
        vecs[8]  = mk(1, 1, 11'h020, 32'h55AA55AA, 0, 0, 11'h000, 32'h0,        1, 0);
        vecs[9]  = mk(0, 0, 11'h000, 32'h0,        1, 0, 11'h020, 32'h0,        0, 1);
        vecs[10] = mk(1, 1, 11'h030, 32'h1,        1, 1, 11'h031, 32'h2,        0, 1);
        vecs[11] = mk(1, 1, 11'h030, 32'h1,        0, 0, 11'h000, 32'h0,        1, 0);
        vecs[12] = mk(0, 0, 11'h000, 32'h0,        1, 0, 11'h030, 32'h0,        0, 1);
        vecs[13] = mk(1, 0, 11'h031, 32'h0,        0, 0, 11'h000, 32'h0,        1, 0);
        vecs[14] = idle;

        // Reset held from time zero, so the first edge clears state.
        w_rst_n = 1'b0;
        w_req0 = 0; w_req1 = 0; w_we0 = 0; w_we1 = 0;
        w_addr0 = '0; w_addr1 = '0; w_wdata0 = '0; w_wdata1 = '0;
        @(negedge w_clk);

        // Reset held while both ports request writes to address 5: no grant, no write.
        step(mk(1, 1, 11'h005, 32'hAAAA0000, 1, 1, 11'h005, 32'hBBBB0000, 0, 0), 1'b0);
        step(mk(1, 1, 11'h005, 32'hAAAA0000, 1, 1, 11'h005, 32'hBBBB0000, 0, 0), 1'b0);
        chk("mem5_unchanged", mem[5], ref_mem[5]);
        step(idle, 1'b1);

        for (int i = 0; i < 15; i++) step(vecs[i], 1'b1);
        chk("mem7ff_written", mem[11'h7FF], 32'hDEADBEEF);

        // Port 1 read presented while reset is asserted: no rvalid afterwards.
        step(mk(0, 0, 11'h000, 32'h0, 1, 0, 11'h002, 32'h0, 0, 0), 1'b0);
        step(idle, 1'b1);
        step(idle, 1'b1);

        // Both ports request continuously; the starvation counter starts from zero.
        for (int i = 0; i < 10; i++) begin
`ifdef ARB_STARVE_GUARD_EN
            step(mk(1, 0, 11'h001, 32'h0, 1, 0, 11'h002, 32'h0,
                    (i % 5) == 4, (i % 5) != 4), 1'b1);
`else
            step(mk(1, 0, 11'h001, 32'h0, 1, 0, 11'h002, 32'h0, 0, 1), 1'b1);
`endif
        end
        step(idle, 1'b1);
        step(idle, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
